// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution block.
// Holds the funct3 branch encodings, the ALU flag bit indices and the
// output-register FSM state type.
package branch_resolve_pkg;

  // funct3 branch encodings
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Flag bit positions for the A-B compare result
  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_NEG   = 1;
  localparam int unsigned FLAG_CARRY = 2;
  localparam int unsigned FLAG_OVF   = 3;

  // Output register occupancy
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluation.
// Ports:
//   funct3  - branch type
//   flags   - ALU flags from A-B {ovf, carry, neg, zero}
//   taken   - branch condition holds
//   illegal - funct3 is not a branch encoding (taken forced to 0)
module branch_cond
  import branch_resolve_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [3:0] flags,
  output logic       taken,
  output logic       illegal
);

  logic lt_signed;

  // Signed less-than from a subtract is N xor V.
  assign lt_signed = flags[FLAG_NEG] ^ flags[FLAG_OVF];

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = flags[FLAG_ZERO];
      F3_BNE:  taken = ~flags[FLAG_ZERO];
      F3_BLT:  taken = lt_signed;
      F3_BGE:  taken = ~lt_signed;
      // Carry set means no borrow, i.e. A >= B unsigned.
      F3_BLTU: taken = ~flags[FLAG_CARRY];
      F3_BGEU: taken = flags[FLAG_CARRY];
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution stage: evaluates the branch condition from ALU flags,
// computes the correct next PC and the mispredict indication, and holds
// the result in a one-entry output register with valid/ready handshake.
// Optional feature macro: BRANCH_STATS_EN adds br_count and mp_count.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   in_valid/in_ready - input handshake
//   funct3, flags     - branch type and ALU compare flags
//   pc, imm           - branch address and sign-extended offset
//   pred_taken        - front-end prediction
//   flush             - drop held result and any same-cycle input
//   out_valid/out_ready - output handshake
//   taken, mispredict, illegal, redirect_pc - resolved result
//   br_count, mp_count - legal branch / mispredict counters (stats build)
module branch_resolve
  import branch_resolve_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  funct3,
  input  logic [3:0]  flags,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic        pred_taken,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        taken,
  output logic        mispredict,
  output logic        illegal,
  output logic [31:0] redirect_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] br_count,
  output logic [31:0] mp_count
`endif
);

  state_e      state;
  logic        taken_d;
  logic        illegal_d;
  logic        mispredict_d;
  logic [31:0] redirect_d;
  logic        accept;

  branch_cond u_cond (
    .funct3  (funct3),
    .flags   (flags),
    .taken   (taken_d),
    .illegal (illegal_d)
  );

  assign mispredict_d = taken_d ^ pred_taken;
  assign redirect_d   = taken_d ? (pc + imm) : (pc + 32'd4);

  assign out_valid = (state == FULL);
  // Reset term keeps the input closed while the register is being cleared.
  assign in_ready  = (~out_valid | out_ready) & ~flush & ~reset;
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      taken       <= 1'b0;
      mispredict  <= 1'b0;
      illegal     <= 1'b0;
      redirect_pc <= '0;
`ifdef BRANCH_STATS_EN
      br_count    <= '0;
      mp_count    <= '0;
`endif
    end else begin
      if (flush) begin
        state <= EMPTY;
      end else if (accept) begin
        state       <= FULL;
        taken       <= taken_d;
        mispredict  <= mispredict_d;
        illegal     <= illegal_d;
        redirect_pc <= redirect_d;
      end else if (out_valid && out_ready) begin
        state <= EMPTY;
      end
`ifdef BRANCH_STATS_EN
      if (accept && !illegal_d) br_count <= br_count + 32'd1;
      if (accept && mispredict_d) mp_count <= mp_count + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [3:0]  flags;
  logic [31:0] pc;
  logic [31:0] imm;
  logic        pred_taken;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        taken;
  logic        mispredict;
  logic        illegal;
  logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_count;
  logic [31:0] mp_count;
`endif

  int unsigned n_tests;
  int unsigned n_fail;
  logic [31:0] exp_br;
  logic [31:0] exp_mp;

  branch_resolve dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .funct3      (funct3),
    .flags       (flags),
    .pc          (pc),
    .imm         (imm),
    .pred_taken  (pred_taken),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .taken       (taken),
    .mispredict  (mispredict),
    .illegal     (illegal),
    .redirect_pc (redirect_pc)
`ifdef BRANCH_STATS_EN
    ,
    .br_count    (br_count),
    .mp_count    (mp_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] f3, input logic [3:0] fl,
                       input logic [31:0] p, input logic [31:0] im, input logic pr);
    in_valid   = v;
    funct3     = f3;
    flags      = fl;
    pc         = p;
    imm        = im;
    pred_taken = pr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 3'b000, 4'b0000, '0, '0, 1'b0);
    flush = 1'b0;
    out_ready = 1'b1;
    #2;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
    end
    step();
    step();
    n_tests++;
    if (out_valid !== 1'b0 || taken !== 1'b0 || mispredict !== 1'b0 ||
        illegal !== 1'b0 || redirect_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b t=%b m=%b i=%b pc=%h exp all 0",
               out_valid, taken, mispredict, illegal, redirect_pc);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready);
    end
    exp_br = '0;
    exp_mp = '0;
  endtask

  task automatic test_beq();
    drive(1'b1, 3'b000, 4'b0001, 32'h100, 32'h20, 1'b0);
    step();
    exp_br++; exp_mp++;
    n_tests++;
    if (out_valid !== 1'b1 || taken !== 1'b1 || mispredict !== 1'b1 ||
        illegal !== 1'b0 || redirect_pc !== 32'h120) begin
      n_fail++;
      $display("FAIL beq_taken got v=%b t=%b m=%b i=%b pc=%h exp v=1 t=1 m=1 i=0 pc=00000120",
               out_valid, taken, mispredict, illegal, redirect_pc);
    end
    drive(1'b0, 3'b000, 4'b0000, '0, '0, 1'b0);
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL beq_drain got out_valid=%b exp=0", out_valid);
    end
  endtask

  typedef struct {
    logic [2:0] f3;
    logic [3:0] fl;
    logic       pred;
    logic       exp_t;
  } vec_t;

  task automatic test_conditions();
    vec_t vecs[10];
    logic [31:0] p;
    logic [31:0] exp_pc;
    vecs[0] = '{3'b001, 4'b0001, 1'b0, 1'b0}; // BNE Z=1
    vecs[1] = '{3'b001, 4'b0000, 1'b0, 1'b1}; // BNE Z=0
    vecs[2] = '{3'b100, 4'b1000, 1'b1, 1'b1}; // BLT V only
    vecs[3] = '{3'b101, 4'b1000, 1'b1, 1'b0}; // BGE V only
    vecs[4] = '{3'b101, 4'b0000, 1'b0, 1'b1}; // BGE none
    vecs[5] = '{3'b110, 4'b0100, 1'b1, 1'b0}; // BLTU C
    vecs[6] = '{3'b111, 4'b0100, 1'b0, 1'b1}; // BGEU C
    vecs[7] = '{3'b100, 4'b1010, 1'b0, 1'b0}; // BLT N and V
    vecs[8] = '{3'b110, 4'b0000, 1'b0, 1'b1}; // BLTU no C
    vecs[9] = '{3'b000, 4'b0000, 1'b1, 1'b0}; // BEQ Z=0
    out_ready = 1'b1;
    // Back-to-back stream: each accept replaces the previous result.
    for (int i = 0; i < 10; i++) begin
      p = 32'h1000 + 32'(i) * 32'h10;
      drive(1'b1, vecs[i].f3, vecs[i].fl, p, 32'h40, vecs[i].pred);
      exp_pc = vecs[i].exp_t ? (p + 32'h40) : (p + 32'h4);
      step();
      exp_br++;
      if (vecs[i].exp_t ^ vecs[i].pred) exp_mp++;
      n_tests++;
      if (out_valid !== 1'b1 || taken !== vecs[i].exp_t ||
          mispredict !== (vecs[i].exp_t ^ vecs[i].pred) ||
          illegal !== 1'b0 || redirect_pc !== exp_pc) begin
        n_fail++;
        $display("FAIL cond_vec%0d got v=%b t=%b m=%b i=%b pc=%h exp v=1 t=%b m=%b i=0 pc=%h",
                 i, out_valid, taken, mispredict, illegal, redirect_pc,
                 vecs[i].exp_t, vecs[i].exp_t ^ vecs[i].pred, exp_pc);
      end
    end
    drive(1'b0, 3'b000, 4'b0000, '0, '0, 1'b0);
    step();
  endtask

  task automatic test_wrap();
    drive(1'b1, 3'b000, 4'b0001, 32'hFFFF_FFF0, 32'h20, 1'b1);
    step();
    exp_br++;
    n_tests++;
    if (redirect_pc !== 32'h0000_0010 || taken !== 1'b1 || mispredict !== 1'b0) begin
      n_fail++; $display("FAIL wrap_taken got pc=%h t=%b m=%b exp pc=00000010 t=1 m=0",
                         redirect_pc, taken, mispredict);
    end
    drive(1'b1, 3'b001, 4'b0001, 32'hFFFF_FFFC, 32'h20, 1'b0);
    step();
    exp_br++;
    n_tests++;
    if (redirect_pc !== 32'h0000_0000 || taken !== 1'b0) begin
      n_fail++; $display("FAIL wrap_fallthrough got pc=%h t=%b exp pc=00000000 t=0",
                         redirect_pc, taken);
    end
    drive(1'b1, 3'b000, 4'b0001, 32'h100, 32'hFFFF_FFF0, 1'b1);
    step();
    exp_br++;
    n_tests++;
    if (redirect_pc !== 32'h0000_00F0) begin
      n_fail++; $display("FAIL negative_imm got pc=%h exp=000000f0", redirect_pc);
    end
    drive(1'b0, 3'b000, 4'b0000, '0, '0, 1'b0);
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 4'b0001, 32'h200, 32'h8, 1'b1); // A: taken -> 0x208
    step();
    exp_br++;
    drive(1'b1, 3'b001, 4'b0001, 32'h300, 32'h8, 1'b1); // B: not taken -> 0x304
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_in_ready cyc%0d got=%b exp=0", i, in_ready);
      end
      step();
      n_tests++;
      if (out_valid !== 1'b1 || taken !== 1'b1 || mispredict !== 1'b0 ||
          redirect_pc !== 32'h208) begin
        n_fail++;
        $display("FAIL stall_hold cyc%0d got v=%b t=%b m=%b pc=%h exp v=1 t=1 m=0 pc=00000208",
                 i, out_valid, taken, mispredict, redirect_pc);
      end
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL drain_accept_in_ready got=%b exp=1", in_ready);
    end
    step();
    exp_br++; exp_mp++;
    n_tests++;
    if (out_valid !== 1'b1 || taken !== 1'b0 || mispredict !== 1'b1 ||
        redirect_pc !== 32'h304) begin
      n_fail++;
      $display("FAIL no_bubble got v=%b t=%b m=%b pc=%h exp v=1 t=0 m=1 pc=00000304",
               out_valid, taken, mispredict, redirect_pc);
    end
    drive(1'b0, 3'b000, 4'b0000, '0, '0, 1'b0);
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain got out_valid=%b exp=0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 4'b0001, 32'h400, 32'h10, 1'b0);
    step();
    exp_br++; exp_mp++;
    drive(1'b1, 3'b001, 4'b0000, 32'h500, 32'h10, 1'b0);
    flush = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_in_ready got=%b exp=0", in_ready);
    end
    step();
    flush = 1'b0;
    drive(1'b0, 3'b000, 4'b0000, '0, '0, 1'b0);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_clear got out_valid=%b exp=0", out_valid);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_dropped got out_valid=%b exp=0", out_valid);
    end
`ifdef BRANCH_STATS_EN
    n_tests++;
    if (br_count !== exp_br || mp_count !== exp_mp) begin
      n_fail++; $display("FAIL flush_counts got br=%0d mp=%0d exp br=%0d mp=%0d",
                         br_count, mp_count, exp_br, exp_mp);
    end
`endif
    out_ready = 1'b1;
  endtask

  task automatic test_illegal();
    drive(1'b1, 3'b010, 4'b0001, 32'h600, 32'h40, 1'b1);
    step();
    exp_mp++;
    n_tests++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || taken !== 1'b0 ||
        mispredict !== 1'b1 || redirect_pc !== 32'h604) begin
      n_fail++;
      $display("FAIL illegal_010 got v=%b i=%b t=%b m=%b pc=%h exp v=1 i=1 t=0 m=1 pc=00000604",
               out_valid, illegal, taken, mispredict, redirect_pc);
    end
    drive(1'b1, 3'b011, 4'b0100, 32'h700, 32'h40, 1'b0);
    step();
    n_tests++;
    if (illegal !== 1'b1 || taken !== 1'b0 || mispredict !== 1'b0) begin
      n_fail++; $display("FAIL illegal_011 got i=%b t=%b m=%b exp i=1 t=0 m=0",
                         illegal, taken, mispredict);
    end
    drive(1'b0, 3'b000, 4'b0000, '0, '0, 1'b0);
    step();
`ifdef BRANCH_STATS_EN
    n_tests++;
    if (br_count !== exp_br || mp_count !== exp_mp) begin
      n_fail++; $display("FAIL stat_counts got br=%0d mp=%0d exp br=%0d mp=%0d",
                         br_count, mp_count, exp_br, exp_mp);
    end
`endif
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 4'b0001, 32'h800, 32'h40, 1'b0);
    step();
    drive(1'b0, 3'b000, 4'b0000, '0, '0, 1'b0);
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_setup got out_valid=%b exp=1", out_valid);
    end
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || taken !== 1'b0 || mispredict !== 1'b0 ||
        redirect_pc !== 32'h0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async got v=%b t=%b m=%b pc=%h rdy=%b exp all 0",
               out_valid, taken, mispredict, redirect_pc, in_ready);
    end
`ifdef BRANCH_STATS_EN
    n_tests++;
    if (br_count !== 32'h0 || mp_count !== 32'h0) begin
      n_fail++; $display("FAIL reset_counts got br=%0d mp=%0d exp 0 0", br_count, mp_count);
    end
`endif
    step();
    reset = 1'b0;
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_empty got out_valid=%b exp=0", out_valid);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_beq();
    test_conditions();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
